// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master) and memory (slave).
interface ifetch_unit_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns PC and IR, issues one memory request per fetch_req,
// applies branch loads and stops fetching once an HLT opcode is loaded.
module ifetch_unit #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [3:0]    HLT_OP   = 4'd15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic          br_load,
  input  logic [AW-1:0] br_addr,
  ifetch_unit_if.master im,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [AW-1:0] pc,
  output logic          ir_valid,
  output logic          busy,
  output logic          halted,
  output logic          fetch_ovr
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e        state_q;
  logic          br_pend_q;
  logic [AW-1:0] br_tgt_q;

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc        <= RESET_PC;
      ir        <= '0;
      im.req    <= 1'b0;
      im.addr   <= RESET_PC;
      ir_valid  <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      fetch_ovr <= 1'b0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
    end else begin
      ir_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fetch_req && !halted) begin
            im.addr <= br_load ? br_addr : pc;
            im.req  <= 1'b1;
            busy    <= 1'b1;
            state_q <= StWait;
          end else if (fetch_req) begin
            fetch_ovr <= 1'b1;
          end
          if (br_load) begin
            pc <= br_addr;
          end
        end
        StWait: begin
          if (fetch_req) begin
            fetch_ovr <= 1'b1;
          end
          if (im.ack) begin
            ir        <= im.rdata;
            // A branch arriving with the ack takes priority over an older pending one.
            if (br_load) begin
              pc <= br_addr;
            end else if (br_pend_q) begin
              pc <= br_tgt_q;
            end else begin
              pc <= im.addr + AW'(1);
            end
            br_pend_q <= 1'b0;
            im.req    <= 1'b0;
            busy      <= 1'b0;
            ir_valid  <= 1'b1;
            if (im.rdata[31:28] == HLT_OP) begin
              halted <= 1'b1;
            end
            state_q <= StIdle;
          end else if (br_load) begin
            br_pend_q <= 1'b1;
            br_tgt_q  <= br_addr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a vector table of single fetches plus hand-written
// sequences for overrun, branch-in-wait, wrap, halt and reset mid-fetch.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic        br_load = 1'b0;
  logic [15:0] br_addr = '0;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] pc;
  logic        ir_valid;
  logic        busy;
  logic        halted;
  logic        fetch_ovr;

  int checks = 0;
  int errors = 0;

  ifetch_unit_if #(.AW(16), .DW(32)) im_bus ();

  ifetch_unit #(
    .AW      (16),
    .DW      (32),
    .RESET_PC(16'h0000),
    .HLT_OP  (4'd15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_req(fetch_req),
    .br_load  (br_load),
    .br_addr  (br_addr),
    .im       (im_bus),
    .ir       (ir),
    .opcode   (opcode),
    .mm       (mm),
    .pc       (pc),
    .ir_valid (ir_valid),
    .busy     (busy),
    .halted   (halted),
    .fetch_ovr(fetch_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [15:0] baddr;
    int          dly;
    logic [31:0] rdata;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
    logic [3:0]  exp_op;
    logic [3:0]  exp_mm;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic br, input logic [15:0] baddr, input int dly,
                          input logic [31:0] rdata, input logic [15:0] exp_addr,
                          input logic [15:0] exp_pc, input logic [3:0] exp_op,
                          input logic [3:0] exp_mm);
    logic [31:0] ir_before;
    ir_before = ir;
    fetch_req = 1'b1;
    br_load   = br;
    br_addr   = baddr;
    tick;
    fetch_req = 1'b0;
    br_load   = 1'b0;
    chk("req_rise", im_bus.req, 1);
    chk("req_addr", im_bus.addr, exp_addr);
    chk("busy_hi", busy, 1);
    for (int i = 0; i < dly; i++) begin
      tick;
      chk("req_hold", im_bus.req, 1);
      chk("addr_hold", im_bus.addr, exp_addr);
      chk("ir_hold", ir, ir_before);
      chk("irv_early", ir_valid, 0);
    end
    im_bus.ack   = 1'b1;
    im_bus.rdata = rdata;
    tick;
    im_bus.ack   = 1'b0;
    im_bus.rdata = '0;
    chk("ir_load", ir, rdata);
    chk("irv_pulse", ir_valid, 1);
    chk("pc_after", pc, exp_pc);
    chk("opcode", opcode, exp_op);
    chk("mm", mm, exp_mm);
    chk("busy_lo", busy, 0);
    chk("req_drop", im_bus.req, 0);
    tick;
    chk("irv_single", ir_valid, 0);
  endtask

  initial begin
    im_bus.ack   = 1'b0;
    im_bus.rdata = '0;

    vecs[0] = '{1'b0, 16'h0000, 0, 32'h8100_0003, 16'h0000, 16'h0001, 4'h8, 4'h1};
    vecs[1] = '{1'b0, 16'h0000, 3, 32'h1234_5678, 16'h0001, 16'h0002, 4'h1, 4'h2};
    vecs[2] = '{1'b1, 16'h0010, 1, 32'h2300_0000, 16'h0010, 16'h0011, 4'h2, 4'h3};
    vecs[3] = '{1'b0, 16'h0000, 0, 32'h0000_0000, 16'h0011, 16'h0012, 4'h0, 4'h0};

    // Reset values before any clock edge
    #3;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 32'h0);
    chk("rst_req", im_bus.req, 0);
    chk("rst_addr", im_bus.addr, 16'h0000);
    chk("rst_irv", ir_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ovr", fetch_ovr, 0);
    chk("rst_opmm", {opcode, mm}, 8'h00);
    tick;
    rst = 1'b0;
    tick;

    for (int v = 0; v < 4; v++) begin
      do_fetch(vecs[v].br, vecs[v].baddr, vecs[v].dly, vecs[v].rdata, vecs[v].exp_addr,
               vecs[v].exp_pc, vecs[v].exp_op, vecs[v].exp_mm);
    end

    // Long ack wait with an overrun pulse mid-wait
    chk("ovr_clear", fetch_ovr, 0);
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    chk("ovr_addr", im_bus.addr, 16'h0012);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) fetch_req = 1'b1;
      tick;
      fetch_req = 1'b0;
      chk("ovr_req_hold", im_bus.req, 1);
      chk("ovr_addr_hold", im_bus.addr, 16'h0012);
      chk("ovr_ir_hold", ir, 32'h0);
    end
    chk("ovr_set", fetch_ovr, 1);
    im_bus.ack   = 1'b1;
    im_bus.rdata = 32'h4500_0000;
    tick;
    im_bus.ack = 1'b0;
    chk("ovr_pc", pc, 16'h0013);
    chk("ovr_ir", ir, 32'h4500_0000);
    tick;
    chk("ovr_no_extra_req", im_bus.req, 0);
    chk("ovr_busy", busy, 0);

    // Branch during wait, last one wins; back-to-back fetch; branch coincident with ack
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    chk("brw_addr", im_bus.addr, 16'h0013);
    br_load = 1'b1;
    br_addr = 16'h0050;
    tick;
    br_addr = 16'h0040;
    tick;
    br_load = 1'b0;
    tick;
    chk("brw_addr_hold", im_bus.addr, 16'h0013);
    im_bus.ack   = 1'b1;
    im_bus.rdata = 32'h5600_0000;
    tick;
    im_bus.ack = 1'b0;
    chk("brw_ir", ir, 32'h5600_0000);
    chk("brw_pc", pc, 16'h0040);
    chk("b2b_irv", ir_valid, 1);
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    chk("b2b_req", im_bus.req, 1);
    chk("b2b_addr", im_bus.addr, 16'h0040);
    br_load      = 1'b1;
    br_addr      = 16'h0077;
    im_bus.ack   = 1'b1;
    im_bus.rdata = 32'h6700_0000;
    tick;
    br_load    = 1'b0;
    im_bus.ack = 1'b0;
    chk("brack_pc", pc, 16'h0077);
    chk("brack_ir", ir, 32'h6700_0000);
    tick;

    // IDLE branch load, PC wrap, branch with fetch in same cycle
    br_load = 1'b1;
    br_addr = 16'hFFFF;
    tick;
    br_load = 1'b0;
    chk("idle_br_pc", pc, 16'hFFFF);
    chk("idle_br_noreq", im_bus.req, 0);
    do_fetch(1'b0, 16'h0000, 0, 32'h7000_0000, 16'hFFFF, 16'h0000, 4'h7, 4'h0);
    do_fetch(1'b1, 16'h0010, 0, 32'h7100_0000, 16'h0010, 16'h0011, 4'h7, 4'h1);

    // Halt
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_ovr", fetch_ovr, 0);
    chk("rst2_pc", pc, 16'h0000);
    tick;
    do_fetch(1'b0, 16'h0000, 1, 32'hF000_0000, 16'h0000, 16'h0001, 4'hF, 4'h0);
    chk("hlt_set", halted, 1);
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    chk("hlt_noreq", im_bus.req, 0);
    chk("hlt_nobusy", busy, 0);
    chk("hlt_ovr", fetch_ovr, 1);
    tick;
    chk("hlt_noreq2", im_bus.req, 0);
    br_load = 1'b1;
    br_addr = 16'h0033;
    tick;
    br_load = 1'b0;
    chk("hlt_br_pc", pc, 16'h0033);
    chk("hlt_sticky", halted, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("hlt_rst_halted", halted, 0);
    chk("hlt_rst_ovr", fetch_ovr, 0);
    chk("hlt_rst_pc", pc, 16'h0000);
    tick;
    rst = 1'b0;
    tick;

    // Reset mid-wait, then a stale ack
    fetch_req = 1'b1;
    tick;
    fetch_req = 1'b0;
    chk("mid_req", im_bus.req, 1);
    tick;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", im_bus.req, 0);
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_busy", busy, 0);
    #1;
    rst = 1'b0;
    tick;
    im_bus.ack   = 1'b1;
    im_bus.rdata = 32'h9900_0000;
    tick;
    im_bus.ack = 1'b0;
    chk("late_ack_ir", ir, 32'h0);
    chk("late_ack_irv", ir_valid, 0);
    chk("late_ack_pc", pc, 16'h0000);
    chk("late_ack_req", im_bus.req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
